mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 16 bits: per-requester request, level.
REQ-005 The block SHALL have port in, input, 16 bits: per-requester data bit, sampled with the grant.
REQ-006 The block SHALL have port mask, input, 16 bits: 1 = requester disabled, its req ignored.
REQ-007 The block SHALL have port ack, output, 16 bits: one-hot, 1-cycle pulse marking the requester whose bit was captured.
REQ-008 The block SHALL have port out, output, 1 bit: captured data bit.
REQ-009 The block SHALL have port out_src, output, 4 bits: index of the requester that produced out.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out/out_src hold a valid sample.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the sample when out_valid && out_ready.

Function
REQ-012 Eligible set SHALL be E = req & ~mask.
REQ-013 The output slot SHALL be free in a cycle when out_valid==0, or when out_valid==1 && out_ready==1.
REQ-014 When the slot is free and E!=0, the block SHALL grant exactly one index g, register out<=in[g], out_src<=g, out_valid<=1, and pulse ack[g] in that same cycle (combinational from the registered pointer and current E).
REQ-015 When the slot is free and E==0, out_valid SHALL go to 0 next cycle and ack SHALL be 0.
REQ-016 When the slot is not free, out, out_src and out_valid SHALL hold, ack SHALL be 0, and the pointer SHALL hold.
REQ-017 With FIXED_PRIO=0, the search SHALL start at (ptr+1) mod 16, ascending with wrap 15->0; g is the first eligible index found; ptr<=g on grant.
REQ-018 With FIXED_PRIO=1, g SHALL be the lowest eligible index, and ptr SHALL be unused but still updated.
REQ-019 FSM SHALL have two states. IDLE (out_valid=0) goes to FULL on grant. FULL (out_valid=1) goes to IDLE on accept with E==0, stays FULL on accept with E!=0 (back-to-back, 1 sample/cycle), and stays FULL with no accept.
REQ-020 Latency SHALL be 1 cycle from req asserted (slot free) to out_valid.
REQ-021 Throughput SHALL be one sample per cycle while out_ready=1 and E!=0.
REQ-022 A requester whose req is dropped or masked before grant SHALL never be acked.
REQ-023 A requester keeping req high after ack SHALL be treated as a new request; in round-robin mode it is served again only after all other eligible indices.
REQ-024 Changes to mask SHALL take effect in the same cycle (no pipelining).

Reset
REQ-025 While rst_n==0 at a clock edge: out_valid<=0, out<=0, out_src<=0, ptr<=15 (first search starts at 0), state<=IDLE.
REQ-026 ack SHALL be forced to 0 while rst_n==0.
REQ-027 Reset mid-transfer SHALL discard any held sample without an accept.
REQ-028 The first grant after reset release SHALL be possible in the first cycle with rst_n==1.

Structure
REQ-029 The shared package SHALL hold: requester count 16, index width 4, state encoding IDLE/FULL, and reset pointer value 15.
REQ-030 Data selection SHALL use one sub-module, sel16 (16:1 bit select: in[15:0], sel[3:0] -> out), driven by g.
REQ-031 The round-robin search SHALL be a combinational rotate-and-priority-encode in the top module.

Verification
REQ-032 Reset then req=16'h0001, in=16'h0001, out_ready=1 -> next cycle out_valid=1, out=1, out_src=0; ack=16'h0001 in the grant cycle.
REQ-033 req=16'hFFFF held, out_ready=1, FIXED_PRIO=0 -> out_src sequence 0,1,2,...,15,0 on consecutive cycles, no gaps.
REQ-034 req=16'h8001, ptr=15 after reset, out_ready=0 for 3 cycles after first grant -> out_src=0 held for 4 cycles with no ack; after ready, next out_src=15.
REQ-035 req=16'h00F0, mask=16'h0030, FIXED_PRIO=1 -> only indices 6 and 7 are granted; with req held, out_src=6 repeatedly.
REQ-036 rst_n=0 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_src=0, ack=0; after release with req=16'h0004 -> out_src=2.
REQ-037 req drops to 0 on the accept cycle -> out_valid=0 next cycle, FSM in IDLE, no spurious ack.

Source files
------------

// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared definitions for the 16-way arbitrated bit mux.
//   NREQ     : number of requesters
//   IDXW     : width of a requester index
//   state_t  : output-slot state (IDLE = empty, FULL = holding a sample)
//   PTR_RST  : pointer value after reset, so the first round-robin search starts at 0
package mux16_rr_arbiter_pkg;

    localparam int NREQ = 16;
    localparam int IDXW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] PTR_RST = 4'd15;

endpackage

// File: rtl/mux16_rr_arbiter_sel16.sv
// 16:1 single-bit select.
//   in  : 16 candidate bits
//   sel : index of the bit to pass through
//   out : in[sel]
module sel16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] in,
    input  logic [IDXW-1:0] sel,
    output logic            out
);

    assign out = in[sel];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// 16-requester arbiter that captures one data bit per grant into a
// single-entry output slot with a valid/ready handshake.
//   FIXED_PRIO : 0 = round-robin, 1 = lowest eligible index wins
//   clk, rst_n : clock, synchronous active-low reset
//   req, mask  : request levels and per-requester disables
//   in         : per-requester data bit, captured on grant
//   ack        : one-hot pulse marking the granted requester (combinational)
//   out        : captured data bit, out_src its requester index
//   out_valid  : slot holds a sample; out_ready accepts it
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] ack,
    output logic            out,
    output logic [IDXW-1:0] out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] start, off, g_rr, g_fp, g;
    logic            slot_free, grant, sel_bit;

    assign elig      = req & ~mask;
    assign slot_free = (state == IDLE) || out_ready;
    assign grant     = rst_n && slot_free && (elig != '0);

    // Rotate the eligible vector so bit 0 is the index just after the last
    // winner; the lowest set bit of the rotated vector is then the next in turn.
    always_comb begin
        start = ptr + IDXW'(1);
        rot   = NREQ'({elig, elig} >> start);
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = IDXW'(i);
        g_rr  = start + off;
        g_fp  = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (elig[i]) g_fp = IDXW'(i);
        g     = (FIXED_PRIO != 0) ? g_fp : g_rr;
    end

    assign ack = grant ? (NREQ'(1) << g) : '0;

    sel16 u_sel (
        .in  (in),
        .sel (g),
        .out (sel_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= 1'b0;
            out_src   <= '0;
            ptr       <= PTR_RST;
        end else if (slot_free) begin
            if (elig != '0) begin
                state     <= FULL;
                out_valid <= 1'b1;
                out       <= sel_bit;
                out_src   <= g;
                ptr       <= g;
            end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req, din, mask;
    logic        out_ready;

    logic [15:0] ack   [2];
    logic        dout  [2];
    logic [3:0]  src   [2];
    logic        valid [2];

    int tests = 0;
    int fails = 0;

    // Reference state per instance: 0 = round-robin, 1 = fixed priority
    bit mv   [2];
    int last [2];
    int q0[$], q1[$];

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .in(din), .mask(mask),
        .ack(ack[0]), .out(dout[0]), .out_src(src[0]), .out_valid(valid[0]),
        .out_ready(out_ready)
    );

    mux16_rr_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .in(din), .mask(mask),
        .ack(ack[1]), .out(dout[1]), .out_src(src[1]), .out_valid(valid[1]),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, m, $time, act, exp);
        end
    endtask

    // Winner from the arbitration rules: lowest eligible index, or the first
    // eligible index scanning upward (with wrap) from the one after the last winner.
    function automatic int pick(input int m, input logic [15:0] e);
        if (m == 1) begin
            for (int i = 0; i < 16; i++) if (e[i]) return i;
        end else begin
            for (int k = 1; k <= 16; k++) if (e[(last[m] + k) % 16]) return (last[m] + k) % 16;
        end
        return -1;
    endfunction

    // Producer: predicts ack and the next slot state each cycle, queues granted samples.
    initial begin
        mv[0] = 0; mv[1] = 0; last[0] = 15; last[1] = 15;
        forever begin
            logic [15:0] e, exp_ack;
            int g;
            @(negedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                check("out_valid", m, 32'(valid[m]), 32'(mv[m]));
                e = req & ~mask;
                exp_ack = '0;
                if (!rst_n) begin
                    mv[m] = 0; last[m] = 15;
                    if (m == 0) q0.delete(); else q1.delete();
                end else if (!mv[m] || out_ready) begin
                    if (e != 0) begin
                        g = pick(m, e);
                        exp_ack = 16'(1) << g;
                        if (m == 0) q0.push_back({din[g], 4'(g)});
                        else        q1.push_back({din[g], 4'(g)});
                        mv[m] = 1; last[m] = g;
                    end else begin
                        mv[m] = 0;
                    end
                end
                check("ack", m, 32'(ack[m]), 32'(exp_ack));
            end
        end
    end

    // Monitor: just before each rising edge, pops the expected sample on accept.
    initial begin
        forever begin
            int exp;
            @(negedge clk); #4;
            for (int m = 0; m < 2; m++) begin
                if (rst_n && valid[m] === 1'b1 && out_ready) begin
                    if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                        check("sample_queued", m, 32'(1), 32'(0));
                    end else begin
                        exp = (m == 0) ? q0.pop_front() : q1.pop_front();
                        check("out_src", m, 32'(src[m]), 32'(exp[3:0]));
                        check("out", m, 32'(dout[m]), 32'(exp[4]));
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [15:0] rq, input logic [15:0] iv,
                       input logic [15:0] mk, input logic rdy);
        @(negedge clk);
        rst_n = r; req = rq; din = iv; mask = mk; out_ready = rdy;
    endtask

    initial begin
        rst_n = 0; req = 0; din = 0; mask = 0; out_ready = 0;
        cyc(0, 0, 0, 0, 0);
        // single requester, first grant straight out of reset
        cyc(1, 16'h0001, 16'h0001, 0, 1);
        cyc(1, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 0, 0, 0, 0);
        // all requesting: round-robin walks 0..15 and wraps
        for (int i = 0; i < 18; i++) cyc(1, 16'hFFFF, 16'(i * 16'h3A5B), 0, 1);
        cyc(0, 0, 0, 0, 0);
        // stall with 0 held, then 15 next after release
        cyc(1, 16'h8001, 16'h8000, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 16'h8001, 16'h8000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 16'h8001, 16'h8001, 0, 1);
        // masking: only 6 and 7 eligible
        for (int i = 0; i < 6; i++) cyc(1, 16'h00F0, 16'h0040, 16'h0030, 1);
        // reset while a sample is held and stalled
        cyc(1, 16'h0100, 16'h0100, 0, 0);
        cyc(1, 16'h0100, 16'h0100, 0, 0);
        cyc(0, 16'h0100, 16'h0100, 0, 0);
        cyc(1, 16'h0004, 16'h0004, 0, 1);
        // request drops on the accept cycle
        cyc(1, 16'h0000, 16'h0000, 0, 1);
        cyc(1, 16'h0000, 16'h0000, 0, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] r, mk;
            r  = 16'($urandom);
            if ($urandom_range(3) == 0) r = r & 16'($urandom);
            if ($urandom_range(7) == 0) r = '0;
            mk = ($urandom_range(2) == 0) ? 16'($urandom) : 16'h0;
            cyc(($urandom_range(63) != 0), r, 16'($urandom), mk, ($urandom_range(3) != 0));
        end
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        @(negedge clk); #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
